// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial-product row per clock, valid/ready on both sides.
// Define MULT_SIGNED_EN to compile in two's-complement operation selected per operation by is_signed.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]   count;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   row;
    logic [PW-1:0]   next_acc;
    logic            sub_row;

    function automatic logic [PW-1:0] extend_a(input logic [WIDTH-1:0] v, input logic sgn);
        return sgn ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
    endfunction

`ifdef MULT_SIGNED_EN
    logic sgn_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sgn_reg <= 1'b0;
        else if (state == IDLE && in_valid)
            sgn_reg <= is_signed;
    end

    // The sign row of b carries weight -2^(WIDTH-1), so it is subtracted rather than added.
    assign a_ext   = extend_a(a, is_signed);
    assign sub_row = sgn_reg && (count == LAST);
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_ext   = extend_a(a, 1'b0);
    assign sub_row = 1'b0;
`endif

    always_comb begin
        row      = b_reg[count] ? (a_reg << count) : '0;
        next_acc = sub_row ? (acc - row) : (acc + row);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            acc       <= '0;
            count     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a_ext;
                        b_reg    <= b;
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc   <= next_acc;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        product   <= next_acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // product keeps its value after the handshake until the next result lands
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: transaction-level model plus literal expectations.
module tb_seq_shift_add_multiplier;

    localparam int W = 4;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             is_signed = 1'b0;
    logic             out_ready = 1'b1;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [2*W-1:0]   product;

    logic             in_valid8 = 1'b0;
    logic             is_signed8 = 1'b0;
    logic             out_ready8 = 1'b1;
    logic [7:0]       a8 = '0;
    logic [7:0]       b8 = '0;
    logic             in_ready8;
    logic             out_valid8;
    logic             busy8;
    logic [15:0]      product8;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    seq_shift_add_multiplier #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                                                 input logic sg);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(av);
        sb = longint'(bv);
        if (sg && SIGNED_BUILD) begin
            if (av[W-1]) sa = sa - (longint'(1) << W);
            if (bv[W-1]) sb = sb - (longint'(1) << W);
        end
        p = sa * sb;
        return p[2*W-1:0];
    endfunction

    // Transaction model: result appears W edges after accept, leaves on handshake.
    logic           m_inready = 1'b1;
    logic           m_outv = 1'b0;
    logic           m_busy = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_res = '0;
    int             m_remaining = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inready   <= 1'b1;
            m_outv      <= 1'b0;
            m_busy      <= 1'b0;
            m_prod      <= '0;
            m_remaining <= 0;
        end else if (m_inready && in_valid) begin
            m_inready   <= 1'b0;
            m_busy      <= 1'b1;
            m_remaining <= W;
            m_res       <= model_mul(a, b, is_signed);
        end else if (m_remaining > 0) begin
            m_remaining <= m_remaining - 1;
            if (m_remaining == 1) begin
                m_outv <= 1'b1;
                m_prod <= m_res;
            end
        end else if (m_outv && out_ready) begin
            m_outv    <= 1'b0;
            m_busy    <= 1'b0;
            m_inready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_inready);
            check("out_valid", out_valid, m_outv);
            check("busy", busy, m_busy);
            check("product", product, m_prod);
        end
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg,
                          input logic [2*W-1:0] exp, input int hold);
        int lat;
        lat = 0;
        while (!in_ready && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("idle_before_op", in_ready, 1'b1);
        a = av; b = bv; is_signed = sg;
        out_ready = (hold == 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = ~bv;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W);
        check("product_lit", product, exp);
        check("in_ready_in_done", in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            a = W'(i); b = W'(i + 3);
            @(posedge clk); #1;
            check("held_valid", out_valid, 1'b1);
            check("held_product", product, exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("after_hs_valid", out_valid, 1'b0);
        check("after_hs_ready", in_ready, 1'b1);
        check("after_hs_product", product, exp);
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
        int lat;
        a8 = av; b8 = bv;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency8", lat, 8);
        check("product8", product8, exp);
        @(posedge clk); #1;
        check("ready8_after_hs", in_ready8, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        check("model_pin_ff", model_mul(4'hF, 4'hF, 1'b0), 8'hE1);
        check("model_pin_67", model_mul(4'h6, 4'h7, 1'b0), 8'h2A);
        check("model_pin_8f_u", model_mul(4'h8, 4'hF, 1'b0), 8'h78);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_product", product, 8'h00);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_op(4'd15, 4'd15, 1'b0, 8'hE1, 0);
        run_op(4'd0, 4'd9, 1'b0, 8'h00, 0);
        run_op(4'd9, 4'd1, 1'b0, 8'h09, 0);
        run_op(4'd6, 4'd7, 1'b0, 8'h2A, 5);

        // Abort an operation two rows in
        a = 4'd9; b = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_product", product, 8'h00);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'd3, 4'd5, 1'b0, 8'h0F, 0);

`ifdef MULT_SIGNED_EN
        run_op(4'd8, 4'd8, 1'b1, 8'h40, 0);
        run_op(4'd8, 4'd7, 1'b1, 8'hC8, 0);
        run_op(4'd7, 4'd15, 1'b1, 8'hF9, 0);
        run_op(4'd8, 4'd15, 1'b1, 8'h08, 0);
`else
        run_op(4'd8, 4'd15, 1'b1, 8'h78, 0);
`endif
        run_op(4'd8, 4'd8, 1'b0, 8'h40, 0);
        run_op(4'd15, 4'd0, 1'b0, 8'h00, 2);

        run8(8'd255, 8'd255, 16'hFE01);
        run8(8'd0, 8'd255, 16'h0000);
        run8(8'd128, 8'd2, 16'h0100);
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(ra, rb, {8'h00, ra} * {8'h00, rb});
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
